prog_timer: RTL and testbench
=============================

Name: prog_timer

Overview:
Programmable down-counting timer. It extends the basic load/count/done timer with parametrised width, a clock prescaler, one-shot and periodic (auto-reload) modes, enable gating with pause/hold, and a synchronous abort. It sits next to game/FSM control logic as the shared delay and periodic-event source. It produces a one-cycle `done` pulse, a sticky `expired` flag, and the live count.

Parameters:
WIDTH, 16, width of count, `in` and the reload register
PRESCALE_W, 8, width of the prescaler divisor and the internal prescaler counter

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  synchronous, active-high reset
load  input  1  latch a new count and configuration; starts the timer
in  input  WIDTH  start/reload value, sampled on load
prescale  input  PRESCALE_W  divisor P, sampled on load; count decrements once every P+1 enabled cycles
periodic  input  1  mode, sampled on load: 0 = one-shot, 1 = auto-reload
enable  input  1  level; 1 = count, 0 = hold (pause)
stop  input  1  abort; return to IDLE without a done pulse
count  output  WIDTH  current count value
done  output  1  one-cycle pulse at each terminal count
expired  output  1  sticky; set when a one-shot timer reaches terminal count
busy  output  1  1 when state is RUN or HOLD

Behaviour:
- Reset:
  - On a rising edge with `rst` = 1: state = IDLE; count, reload register, prescaler counter (pc), P register and mode register are all cleared.
  - done = 0, expired = 0, busy = 0 from the next cycle.
- States: IDLE, RUN, HOLD, EXPIRED.
- Priority per edge: rst > load > stop > tick / enable handling.
- load = 1 (from any state):
  - count and reload ← `in`; P ← `prescale`; mode ← `periodic`; pc ← 0; expired ← 0; done ← 0.
  - If `in` = 0: next state = EXPIRED, expired = 1, done = 1 for the following cycle, in either mode.
  - Otherwise: next state = RUN if `enable` = 1, else HOLD.
- stop = 1 (with no load): state ← IDLE; count ← 0; pc ← 0; expired ← 0; no done pulse.
- RUN with enable = 0: go to HOLD. count and pc hold.
- HOLD with enable = 1: go to RUN. Counting resumes from the held pc; no prescaler restart.
- Tick in RUN with enable = 1:
  - If pc == P: tick fires and pc ← 0. Otherwise pc ← pc + 1.
  - P = 0 means a tick on every enabled cycle.
- On a tick with count > 1: count ← count − 1.
- On a tick with count == 1 (terminal), done is registered as 1 for exactly one cycle, plus:
  - One-shot: count ← 0, state ← EXPIRED, expired ← 1.
  - Periodic: count ← reload, stay in RUN; expired stays 0.
- Latency, with enable held high: after a load of N ≥ 1, done is high in the cycle that follows the N·(P+1)-th rising edge after the load edge.
- Period in periodic mode: done pulses every N·(P+1) cycles.
- EXPIRED state:
  - count = 0; expired held at 1.
  - Leaves only on load, stop or rst; enable is ignored.
- IDLE: counting, enable and tick are all ignored; count = 0.
- done is never asserted for two consecutive cycles unless P = 0, N = 1 and the mode is periodic. In that case done stays high continuously.
- Simultaneous load and terminal tick: load wins; no done pulse; the new value is loaded.
- Simultaneous stop and terminal tick: stop wins; no done pulse.
- Changing `in`, `prescale` or `periodic` while running has no effect until the next load.
- All arithmetic is unsigned, WIDTH bits wide; count never wraps below 0.

Test Plan:
1. Reset, then load in = 5, P = 0, one-shot, enable = 1 → count goes 5, 4, 3, 2, 1, 0; done high one cycle exactly 5 edges after the load; expired = 1 and held; busy = 0 after expiry.
2. Load in = 3, P = 2, periodic, enable = 1 → done pulses at 9, 18 and 27 cycles after the load; count reloads to 3 after each pulse; expired stays 0.
3. Load in = 4, P = 0, one-shot; drop enable for 3 cycles after the second decrement → state HOLD and count holds at 2; done arrives 3 cycles later than in scenario 1 (8 edges after the load).
4. Load in = 0 → next cycle shows expired = 1 and a single done pulse; state EXPIRED. Then load in = 2 → expired clears and done fires 2 edges later.
5. Load in = 2, P = 0, periodic; assert load with in = 7 on the same edge as the terminal tick → no done pulse; count = 7. Separately, assert stop on the terminal edge → no done pulse; count = 0; state IDLE.
6. Assert rst mid-count (count = 3, in RUN) → next cycle count = 0, done = 0, expired = 0, busy = 0; no later done pulse without a new load.

Source files
------------

// File: rtl/prog_timer_if.sv
// Control/status bundle for prog_timer: load/configuration inputs and the
// count/done/expired/busy status returned by the timer.
interface prog_timer_if #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
);
  logic                  load;
  logic [WIDTH-1:0]      in;
  logic [PRESCALE_W-1:0] prescale;
  logic                  periodic;
  logic                  enable;
  logic                  stop;
  logic [WIDTH-1:0]      count;
  logic                  done;
  logic                  expired;
  logic                  busy;

  modport master (
    output load, in, prescale, periodic, enable, stop,
    input  count, done, expired, busy
  );

  modport slave (
    input  load, in, prescale, periodic, enable, stop,
    output count, done, expired, busy
  );
endinterface

// File: rtl/prog_timer.sv
// Programmable down-counting timer with prescaler, one-shot/periodic modes,
// enable hold and synchronous abort; all outputs come straight from registers.
module prog_timer #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) (
  input logic          clk,
  input logic          rst,
  prog_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HOLD    = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0]      CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]      CNT_ONE  = WIDTH'(1);
  localparam logic [PRESCALE_W-1:0] PC_ZERO  = {PRESCALE_W{1'b0}};
  localparam logic [PRESCALE_W-1:0] PC_ONE   = PRESCALE_W'(1);

  state_t                state_r,   state_n_s;
  logic [WIDTH-1:0]      count_r,   count_n_s;
  logic [WIDTH-1:0]      reload_r,  reload_n_s;
  logic [PRESCALE_W-1:0] pc_r,      pc_n_s;
  logic [PRESCALE_W-1:0] p_r,       p_n_s;
  logic                  mode_r,    mode_n_s;
  logic                  done_r,    done_n_s;
  logic                  expired_r, expired_n_s;
  logic                  busy_r;

  // State and datapath registers; busy is registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      count_r   <= CNT_ZERO;
      reload_r  <= CNT_ZERO;
      pc_r      <= PC_ZERO;
      p_r       <= PC_ZERO;
      mode_r    <= 1'b0;
      done_r    <= 1'b0;
      expired_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_n_s;
      count_r   <= count_n_s;
      reload_r  <= reload_n_s;
      pc_r      <= pc_n_s;
      p_r       <= p_n_s;
      mode_r    <= mode_n_s;
      done_r    <= done_n_s;
      expired_r <= expired_n_s;
      busy_r    <= (state_n_s == ST_RUN) || (state_n_s == ST_HOLD);
    end
  end

  // Next-state and datapath update; load beats stop, stop beats any tick.
  always_comb begin
    state_n_s   = state_r;
    count_n_s   = count_r;
    reload_n_s  = reload_r;
    pc_n_s      = pc_r;
    p_n_s       = p_r;
    mode_n_s    = mode_r;
    done_n_s    = 1'b0;
    expired_n_s = expired_r;

    if (bus.load) begin
      count_n_s  = bus.in;
      reload_n_s = bus.in;
      p_n_s      = bus.prescale;
      mode_n_s   = bus.periodic;
      pc_n_s     = PC_ZERO;
      if (bus.in == CNT_ZERO) begin
        state_n_s   = ST_EXPIRED;
        expired_n_s = 1'b1;
        done_n_s    = 1'b1;
      end else begin
        expired_n_s = 1'b0;
        state_n_s   = bus.enable ? ST_RUN : ST_HOLD;
      end
    end else if (bus.stop) begin
      state_n_s   = ST_IDLE;
      count_n_s   = CNT_ZERO;
      pc_n_s      = PC_ZERO;
      expired_n_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          count_n_s = CNT_ZERO;
        end
        ST_RUN: begin
          if (!bus.enable) begin
            state_n_s = ST_HOLD;
          end else if (pc_r == p_r) begin
            pc_n_s = PC_ZERO;
            if (count_r > CNT_ONE) begin
              count_n_s = count_r - CNT_ONE;
            end else if (count_r == CNT_ONE) begin
              // Terminal tick: periodic reloads and keeps running.
              done_n_s = 1'b1;
              if (mode_r) begin
                count_n_s = reload_r;
              end else begin
                count_n_s   = CNT_ZERO;
                state_n_s   = ST_EXPIRED;
                expired_n_s = 1'b1;
              end
            end else begin
              state_n_s = ST_IDLE;
            end
          end else begin
            pc_n_s = pc_r + PC_ONE;
          end
        end
        ST_HOLD: begin
          if (bus.enable) begin
            state_n_s = ST_RUN;
          end else begin
            state_n_s = ST_HOLD;
          end
        end
        ST_EXPIRED: begin
          count_n_s   = CNT_ZERO;
          expired_n_s = 1'b1;
        end
        default: begin
          state_n_s = ST_IDLE;
          count_n_s = CNT_ZERO;
          pc_n_s    = PC_ZERO;
        end
      endcase
    end
  end

  assign bus.count   = count_r;
  assign bus.done    = done_r;
  assign bus.expired = expired_r;
  assign bus.busy    = busy_r;

endmodule

// File: tb/tb_prog_timer.sv
// Scoreboard bench for prog_timer: each driven cycle queues its expected
// outputs, which are popped and compared one clock later.
module tb_prog_timer;

  logic clk;
  logic rst;

  prog_timer_if #(.WIDTH(16), .PRESCALE_W(8)) bus ();

  prog_timer #(.WIDTH(16), .PRESCALE_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [15:0] cnt;
    logic        dn;
    logic        ex;
    logic        bz;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks;
  int   n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
  task automatic cyc(input string tag, input logic rs, input logic ld,
                     input logic [15:0] din, input logic [7:0] pre, input logic per,
                     input logic en, input logic stp,
                     input logic [15:0] ecnt, input logic edn, input logic eex,
                     input logic ebz);
    exp_t e;
    rst          = rs;
    bus.load     = ld;
    bus.in       = din;
    bus.prescale = pre;
    bus.periodic = per;
    bus.enable   = en;
    bus.stop     = stp;
    sb_q.push_back('{cnt: ecnt, dn: edn, ex: eex, bz: ebz});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({tag, ".count"},   32'(bus.count),   32'(e.cnt));
    chk({tag, ".done"},    32'(bus.done),    32'(e.dn));
    chk({tag, ".expired"}, 32'(bus.expired), 32'(e.ex));
    chk({tag, ".busy"},    32'(bus.busy),    32'(e.bz));
  endtask

  initial begin
    int j;
    n_checks     = 0;
    n_pass       = 0;
    rst          = 1'b1;
    bus.load     = 1'b0;
    bus.in       = 16'd0;
    bus.prescale = 8'd0;
    bus.periodic = 1'b0;
    bus.enable   = 1'b0;
    bus.stop     = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    cyc("rst", 1'b1, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    cyc("idle", 1'b0, 1'b0, 16'd9, 8'd0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);

    // 1: one-shot N=5, P=0
    cyc("s1.load", 1'b0, 1'b1, 16'd5, 8'd0, 1'b0, 1'b1, 1'b0, 16'd5, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++)
      cyc($sformatf("s1.t%0d", k), 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b1, 1'b0,
          16'(5 - k), (k == 5), (k == 5), (k < 5));
    for (int k = 6; k <= 7; k++)
      cyc($sformatf("s1.t%0d", k), 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b1, 1'b0,
          16'd0, 1'b0, 1'b1, 1'b0);

    // 2: periodic N=3, P=2 -> done every 9 cycles
    cyc("s2.load", 1'b0, 1'b1, 16'd3, 8'd2, 1'b1, 1'b1, 1'b0, 16'd3, 1'b0, 1'b0, 1'b1);
    for (int t = 1; t <= 27; t++) begin
      j = t / 3;
      cyc($sformatf("s2.t%0d", t), 1'b0, 1'b0, 16'd8, 8'd0, 1'b0, 1'b1, 1'b0,
          16'(3 - (j % 3)), ((t % 9) == 0), 1'b0, 1'b1);
    end
    cyc("s2.stop", 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b1, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0);

    // 3: one-shot N=4, P=0 with a 3-cycle enable drop after the second decrement
    cyc("s3.load", 1'b0, 1'b1, 16'd4, 8'd0, 1'b0, 1'b1, 1'b0, 16'd4, 1'b0, 1'b0, 1'b1);
    cyc("s3.t1", 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b1, 1'b0, 16'd3, 1'b0, 1'b0, 1'b1);
    cyc("s3.t2", 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b1, 1'b0, 16'd2, 1'b0, 1'b0, 1'b1);
    for (int k = 3; k <= 5; k++)
      cyc($sformatf("s3.hold%0d", k), 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0,
          16'd2, 1'b0, 1'b0, 1'b1);
    cyc("s3.t6", 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b1, 1'b0, 16'd2, 1'b0, 1'b0, 1'b1);
    cyc("s3.t7", 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b1, 1'b0, 16'd1, 1'b0, 1'b0, 1'b1);
    cyc("s3.t8", 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    cyc("s3.t9", 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0);

    // 4: load zero expires immediately, then reload 2
    cyc("s4.load0", 1'b0, 1'b1, 16'd0, 8'd0, 1'b1, 1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    cyc("s4.after", 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    cyc("s4.load2", 1'b0, 1'b1, 16'd2, 8'd0, 1'b0, 1'b1, 1'b0, 16'd2, 1'b0, 1'b0, 1'b1);
    cyc("s4.t1", 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b1, 1'b0, 16'd1, 1'b0, 1'b0, 1'b1);
    cyc("s4.t2", 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    cyc("s4.ign", 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0);

    // 5a: load on the terminal tick wins
    cyc("s5.load", 1'b0, 1'b1, 16'd2, 8'd0, 1'b1, 1'b1, 1'b0, 16'd2, 1'b0, 1'b0, 1'b1);
    cyc("s5.t1", 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b1, 1'b0, 16'd1, 1'b0, 1'b0, 1'b1);
    cyc("s5.ld7", 1'b0, 1'b1, 16'd7, 8'd0, 1'b1, 1'b1, 1'b0, 16'd7, 1'b0, 1'b0, 1'b1);
    cyc("s5.t3", 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b1, 1'b0, 16'd6, 1'b0, 1'b0, 1'b1);
    // 5b: stop on the terminal tick wins
    cyc("s5.reld", 1'b0, 1'b1, 16'd2, 8'd0, 1'b1, 1'b1, 1'b0, 16'd2, 1'b0, 1'b0, 1'b1);
    cyc("s5.r1", 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b1, 1'b0, 16'd1, 1'b0, 1'b0, 1'b1);
    cyc("s5.stop", 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b1, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0);
    cyc("s5.idle", 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);

    // 6: reset mid-count, then nothing happens without a new load
    cyc("s6.load", 1'b0, 1'b1, 16'd5, 8'd0, 1'b0, 1'b1, 1'b0, 16'd5, 1'b0, 1'b0, 1'b1);
    cyc("s6.t1", 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b1, 1'b0, 16'd4, 1'b0, 1'b0, 1'b1);
    cyc("s6.t2", 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b1, 1'b0, 16'd3, 1'b0, 1'b0, 1'b1);
    cyc("s6.rst", 1'b1, 1'b0, 16'd0, 8'd0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++)
      cyc($sformatf("s6.post%0d", k), 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b1, 1'b0,
          16'd0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
